// File: rtl/gray_to_binary.sv
// gray_to_binary
//   Registered Gray-to-binary converter with step checking. Each accepted
//   Gray word is converted to binary one cycle later. It is also compared
//   against the previously accepted word to flag illegal steps (Hamming
//   distance other than one) and to report the count direction (+1 / -1,
//   with modulo wrap-around).

module gray_to_binary #(
    parameter int WIDTH = 4            // code width, legal range 2..32
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active-high
    input  logic [WIDTH-1:0] gray,
    input  logic             in_valid,
    output logic [WIDTH-1:0] binary,
    output logic             out_valid,
    output logic             step_err,
    output logic             dir_up,
    output logic             dir_dn
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_binary;
    logic             r_out_valid;
    logic             r_step_err;
    logic             r_dir_up;
    logic             r_dir_dn;
    logic [WIDTH-1:0] r_prev_gray;     // last accepted Gray word
    logic             r_have_prev;     // r_prev_gray / r_binary are meaningful

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_bin;           // binary value of the incoming word
    logic [WIDTH-1:0] w_diff;          // bits that changed since last word
    logic             w_one_bit;       // exactly one bit changed
    logic [WIDTH-1:0] w_bin_inc;       // previous binary + 1 (mod 2^WIDTH)
    logic [WIDTH-1:0] w_bin_dec;       // previous binary - 1 (mod 2^WIDTH)
    logic             w_is_up;
    logic             w_is_dn;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    // Written as a reduction per bit rather than a chained w_bin[i+1] ^ gray[i]
    // so the combinational block never reads its own output.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bin[i] = ^(gray >> i);
        end
    end

    // Step classification: single-bit-change test and direction compare.
    always_comb begin
        w_diff    = gray ^ r_prev_gray;
        // A power of two has a single bit set: x != 0 and x & (x-1) == 0.
        w_one_bit = (w_diff != '0) && ((w_diff & (w_diff - ONE)) == '0);
        w_bin_inc = r_binary + ONE;
        w_bin_dec = r_binary - ONE;
        // For WIDTH >= 2, +1 and -1 differ, so at most one of these is set.
        w_is_up   = w_one_bit && (w_bin == w_bin_inc);
        w_is_dn   = w_one_bit && (w_bin == w_bin_dec);
    end

    // Result and history registers; results update only on accepted inputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            r_binary    <= '0;
            r_out_valid <= 1'b0;
            r_step_err  <= 1'b0;
            r_dir_up    <= 1'b0;
            r_dir_dn    <= 1'b0;
            r_prev_gray <= '0;
            r_have_prev <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_binary    <= w_bin;
                r_prev_gray <= gray;
                r_have_prev <= 1'b1;
                // The first word after reset has no predecessor: all flags clear.
                r_step_err  <= r_have_prev && !w_one_bit;
                r_dir_up    <= r_have_prev && w_is_up;
                r_dir_dn    <= r_have_prev && w_is_dn;
            end
        end
    end

    // Outputs come straight from registers: no input-to-output comb path.
    assign binary    = r_binary;
    assign out_valid = r_out_valid;
    assign step_err  = r_step_err;
    assign dir_up    = r_dir_up;
    assign dir_dn    = r_dir_dn;

endmodule

// File: tb/tb_gray_to_binary.sv
// tb_gray_to_binary
//   Self-checking bench: directed scenarios plus randomized traffic on a
//   WIDTH=4 instance, checked against a table-driven reference model, and a
//   short directed check of a WIDTH=8 instance.

module tb_gray_to_binary;

    localparam int W4 = 4;
    localparam int W8 = 8;
    localparam int N4 = 1 << W4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic [W4-1:0] gray4     = '0;
    logic          in_valid4 = 1'b0;
    logic [W4-1:0] binary4;
    logic          out_valid4, step_err4, dir_up4, dir_dn4;

    // WIDTH=8 instance
    logic [W8-1:0] gray8     = '0;
    logic          in_valid8 = 1'b0;
    logic [W8-1:0] binary8;
    logic          out_valid8, step_err8, dir_up8, dir_dn8;

    gray_to_binary #(.WIDTH(W4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .gray     (gray4),
        .in_valid (in_valid4),
        .binary   (binary4),
        .out_valid(out_valid4),
        .step_err (step_err4),
        .dir_up   (dir_up4),
        .dir_dn   (dir_dn4)
    );

    gray_to_binary #(.WIDTH(W8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .gray     (gray8),
        .in_valid (in_valid8),
        .binary   (binary8),
        .out_valid(out_valid8),
        .step_err (step_err8),
        .dir_up   (dir_up8),
        .dir_dn   (dir_dn8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the binary value of a Gray word is found by looking
    // it up in a table built from the forward code n -> n ^ (n >> 1).
    // Direction is the modular difference of successive binary values.
    // ------------------------------------------------------------------
    int            inv_tab [N4];
    bit            m_have;
    logic [W4-1:0] m_prev_gray;
    logic [W4-1:0] m_bin;
    bit            m_ov, m_err, m_up, m_dn;

    task automatic model_reset();
        m_have = 0; m_prev_gray = '0; m_bin = '0;
        m_ov = 0; m_err = 0; m_up = 0; m_dn = 0;
    endtask

    task automatic model_accept(input logic [W4-1:0] g);
        int nb, d;
        nb = inv_tab[g];
        if (!m_have) begin
            m_err = 0; m_up = 0; m_dn = 0;
        end else begin
            m_err = ($countones(g ^ m_prev_gray) != 1);
            d     = (nb - int'(m_bin) + N4) % N4;
            m_up  = !m_err && (d == 1);
            m_dn  = !m_err && (d == N4 - 1);
        end
        m_bin       = W4'(nb);
        m_prev_gray = g;
        m_have      = 1;
        m_ov        = 1;
    endtask

    task automatic compare_all(input string where);
        check({where, ".out_valid"}, 32'(out_valid4), 32'(m_ov));
        check({where, ".binary"},    32'(binary4),    32'(m_bin));
        check({where, ".step_err"},  32'(step_err4),  32'(m_err));
        check({where, ".dir_up"},    32'(dir_up4),    32'(m_up));
        check({where, ".dir_dn"},    32'(dir_dn4),    32'(m_dn));
    endtask

    // Present one input to the WIDTH=4 DUT, clock it, then compare 1 ns later.
    task automatic cycle4(input string where, input bit v, input logic [W4-1:0] g);
        in_valid4 = v;
        gray4     = g;
        @(posedge clk);
        if (rst)    model_reset();
        else if (v) model_accept(g);
        else        m_ov = 0;
        #1;
        compare_all(where);
    endtask

    logic [W4-1:0] sweep [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin
        for (int n = 0; n < N4; n++) inv_tab[n ^ (n >> 1)] = n;
        model_reset();

        // Reset state, held asynchronously with no clock edge yet.
        #2;
        compare_all("reset");
        @(posedge clk); #3;
        rst = 1'b0;

        // Full sweep: binary counts 0..15, no step errors, up from 2nd result.
        for (int i = 0; i < 16; i++) begin
            cycle4("sweep", 1'b1, sweep[i]);
            check("sweep.bin_const", 32'(binary4), 32'(i));
            check("sweep.up_const",  32'(dir_up4), 32'(i != 0));
        end

        // Wrap-around both ways.
        cycle4("wrap_up", 1'b1, 4'b0000);
        check("wrap_up.const", {29'd0, dir_up4, step_err4, out_valid4}, 32'b101);
        cycle4("wrap_dn", 1'b1, 4'b1000);
        check("wrap_dn.bin_const", 32'(binary4), 32'hF);
        check("wrap_dn.dn_const",  32'(dir_dn4), 32'd1);

        // Illegal steps: two bits changed, then a repeated word.
        cycle4("bad_a", 1'b1, 4'b0000);
        cycle4("bad_b", 1'b1, 4'b0011);
        check("bad_b.const", {26'd0, binary4, step_err4, dir_up4}, {26'd0, 4'b0010, 1'b1, 1'b0});
        cycle4("bad_rep", 1'b1, 4'b0011);
        check("bad_rep.const", 32'(step_err4), 32'd1);

        // Gaps: outputs hold while in_valid is low.
        cycle4("gap_a", 1'b1, 4'b0110);
        for (int i = 0; i < 3; i++) begin
            cycle4("gap_idle", 1'b0, 4'b1111);
            check("gap_idle.const", {27'd0, binary4, out_valid4}, {27'd0, 4'b0100, 1'b0});
        end
        cycle4("gap_b", 1'b1, 4'b0111);
        check("gap_b.const", {27'd0, binary4, dir_up4}, {27'd0, 4'b0101, 1'b1});

        // Async reset between edges while a result is valid (binary 1010).
        cycle4("pre_rst", 1'b1, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        check("async_rst.const", {27'd0, binary4, out_valid4}, 32'd0);
        // An input presented on an edge while rst is high is ignored.
        cycle4("rst_edge", 1'b1, 4'b0101);
        #2;
        rst = 1'b0;
        cycle4("post_rst", 1'b1, 4'b1101);
        check("post_rst.const", {25'd0, binary4, step_err4, dir_up4, dir_dn4}, {25'd0, 4'b1001, 3'b000});

        // Randomized traffic, biased toward legal single-bit steps.
        for (int it = 0; it < 600; it++) begin
            logic [W4-1:0] g;
            int            sel;
            sel = $urandom_range(0, 9);
            if (sel < 6)      g = m_prev_gray ^ W4'(1 << $urandom_range(0, W4 - 1));
            else if (sel < 7) g = m_prev_gray;
            else              g = W4'($urandom_range(0, N4 - 1));
            cycle4("rand", ($urandom_range(0, 3) != 0), g);
            if ($urandom_range(0, 59) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                compare_all("rand_rst");
                cycle4("rand_rst_edge", 1'b1, W4'($urandom_range(0, N4 - 1)));
                #2;
                rst = 1'b0;
            end
        end
        in_valid4 = 1'b0;

        // WIDTH=8: Gray 1000_0000 -> 1111_1111, then 1000_0001 -> 1111_1110 (down).
        in_valid8 = 1'b1;
        gray8     = 8'b1000_0000;
        @(posedge clk); #1;
        check("w8_a.binary",    32'(binary8),    32'hFF);
        check("w8_a.out_valid", 32'(out_valid8), 32'd1);
        gray8 = 8'b1000_0001;
        @(posedge clk); #1;
        check("w8_b.binary",   32'(binary8),  32'hFE);
        check("w8_b.dir_dn",   32'(dir_dn8),  32'd1);
        check("w8_b.dir_up",   32'(dir_up8),  32'd0);
        check("w8_b.step_err", 32'(step_err8), 32'd0);
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        check("w8_idle.out_valid", 32'(out_valid8), 32'd0);
        check("w8_idle.binary",    32'(binary8),    32'hFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
